// File: rtl/picorv32_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_sram_ctrl
// Purpose  : PicoRV32 native-memory responder driving RW port 0 of a
//            sky130 1rw1r 32x512 SRAM macro, with window decode and a
//            sticky out-of-window error flag.
// Revision : 1.0  initial release
// ============================================================================
module picorv32_sram_ctrl #(
   parameter int          ADDR_WIDTH = 9,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          READ_WAIT  = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  mem_valid,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [3:0]            mem_wstrb,
   output logic                  mem_ready,
   output logic [31:0]           mem_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [3:0]            sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [31:0]           sram_din0,
   input  logic [31:0]           sram_dout0,
   output logic                  busy,
   output logic                  err,
   output logic [31:0]           err_addr,
   input  logic                  err_clr
);

   localparam logic [2:0] c_WAIT_INIT = 3'(READ_WAIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                state_q;
   logic [2:0]            wait_cnt_q;
   logic                  mem_ready_q;
   logic [31:0]           mem_rdata_q;
   logic                  sram_csb0_q;
   logic                  sram_web0_q;
   logic [3:0]            sram_wmask0_q;
   logic [ADDR_WIDTH-1:0] sram_addr0_q;
   logic [31:0]           sram_din0_q;
   logic                  err_q;
   logic [31:0]           err_addr_q;

   logic                  w_in_window;
   logic                  w_unused_addr_bits;

   // Upper address bits select the SRAM window; the low word offset bits
   // address the macro and the byte offset is meaningless for word accesses.
   assign w_in_window        = (mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
   assign w_unused_addr_bits = ^mem_addr[1:0];

   // Transaction FSM; every macro-facing and CPU-facing output is a register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         wait_cnt_q    <= 3'd0;
         mem_ready_q   <= 1'b0;
         mem_rdata_q   <= 32'd0;
         sram_csb0_q   <= 1'b1;
         sram_web0_q   <= 1'b1;
         sram_wmask0_q <= 4'd0;
         sram_addr0_q  <= '0;
         sram_din0_q   <= 32'd0;
         err_q         <= 1'b0;
         err_addr_q    <= 32'd0;
      end else begin
         // Clear first so that a same-cycle out-of-window decode overrides it.
         if (err_clr) begin
            err_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (mem_valid) begin
                  if (w_in_window) begin
                     sram_addr0_q  <= mem_addr[ADDR_WIDTH+1:2];
                     sram_din0_q   <= mem_wdata;
                     sram_wmask0_q <= mem_wstrb;
                     sram_web0_q   <= (mem_wstrb == 4'd0);
                     sram_csb0_q   <= 1'b0;
                     state_q       <= ACCESS;
                  end else begin
                     // Answer without selecting the macro; writes are dropped.
                     err_q       <= 1'b1;
                     err_addr_q  <= mem_addr;
                     mem_rdata_q <= 32'd0;
                     mem_ready_q <= 1'b1;
                     state_q     <= RESP;
                  end
               end
            end
            ACCESS: begin
               // Macro captures on this edge; deselect it right away.
               sram_csb0_q <= 1'b1;
               sram_web0_q <= 1'b1;
               if (!sram_web0_q) begin
                  mem_ready_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  wait_cnt_q <= c_WAIT_INIT;
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt_q != 3'd0) begin
                  wait_cnt_q <= wait_cnt_q - 3'd1;
               end else begin
                  mem_rdata_q <= sram_dout0;
                  mem_ready_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               mem_ready_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_ready   = mem_ready_q;
   assign mem_rdata   = mem_rdata_q;
   assign sram_csb0   = sram_csb0_q;
   assign sram_web0   = sram_web0_q;
   assign sram_wmask0 = sram_wmask0_q;
   assign sram_addr0  = sram_addr0_q;
   assign sram_din0   = sram_din0_q;
   assign busy        = (state_q != IDLE);
   assign err         = err_q;
   assign err_addr    = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv32_sram_ctrl
// Purpose  : Self-checking bench for picorv32_sram_ctrl. Two instances
//            (READ_WAIT 0 and 2), each with a behavioural SRAM port model.
// Revision : 1.0  initial release
// ============================================================================
module tb_picorv32_sram_ctrl;

   logic        clk;
   logic        resetn;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        clr;
   int          sel;

   logic        ready   [2];
   logic [31:0] rdata   [2];
   logic        csb     [2];
   logic        web     [2];
   logic [3:0]  wmask   [2];
   logic [8:0]  saddr   [2];
   logic [31:0] din     [2];
   logic [31:0] dout    [2];
   logic        busy    [2];
   logic        err     [2];
   logic [31:0] erra    [2];

   int          n_checks;
   int          n_fail;
   logic [31:0] exp_q [$];
   logic [31:0] shadow [2][512];
   logic [31:0] last_rd [2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One DUT per READ_WAIT setting, each with its own macro model.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [31:0] mem [512];

      picorv32_sram_ctrl #(
         .ADDR_WIDTH(9),
         .BASE_ADDR (32'h0000_0000),
         .READ_WAIT (2 * gi)
      ) u_dut (
         .clk        (clk),
         .resetn     (resetn),
         .mem_valid  (valid && (sel == gi)),
         .mem_addr   (addr),
         .mem_wdata  (wdata),
         .mem_wstrb  (wstrb),
         .mem_ready  (ready[gi]),
         .mem_rdata  (rdata[gi]),
         .sram_csb0  (csb[gi]),
         .sram_web0  (web[gi]),
         .sram_wmask0(wmask[gi]),
         .sram_addr0 (saddr[gi]),
         .sram_din0  (din[gi]),
         .sram_dout0 (dout[gi]),
         .busy       (busy[gi]),
         .err        (err[gi]),
         .err_addr   (erra[gi]),
         .err_clr    (clr && (sel == gi))
      );

      // Macro port 0: captures on the clock edge while selected.
      always @(posedge clk) begin
         if (!csb[gi]) begin
            if (!web[gi]) begin
               for (int b = 0; b < 4; b++) begin
                  if (wmask[gi][b]) mem[saddr[gi]][8*b +: 8] <= din[gi][8*b +: 8];
               end
            end else begin
               dout[gi] <= mem[saddr[gi]];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one transaction on instance s and check timing and data.
   task automatic do_txn(input int s, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic c);
      logic        in_win;
      int          exp_lat;
      int          csb_lo;
      int          busy_n;
      logic        got;
      logic [31:0] exp_rd;
      in_win = (a[31:11] == 21'd0);
      if (!in_win) begin
         exp_lat    = 1;
         last_rd[s] = 32'd0;
      end else if (ws != 4'd0) begin
         exp_lat = 2;
         for (int b = 0; b < 4; b++) begin
            if (ws[b]) shadow[s][a[10:2]][8*b +: 8] = wd[8*b +: 8];
         end
      end else begin
         exp_lat    = 3 + 2 * s;
         last_rd[s] = shadow[s][a[10:2]];
      end
      exp_q.push_back(last_rd[s]);

      @(negedge clk);
      sel   = s;
      valid = 1'b1;
      addr  = a;
      wdata = wd;
      wstrb = ws;
      clr   = c;
      csb_lo = 0;
      busy_n = 0;
      got    = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
         @(negedge clk);
         clr = 1'b0;
         if (!csb[s]) csb_lo++;
         if (busy[s]) busy_n++;
         if (k == 1 && in_win) begin
            chk("acc_csb", {31'd0, csb[s]}, 32'd0);
            chk("acc_web", {31'd0, web[s]}, {31'd0, ws == 4'd0});
            chk("acc_addr", {23'd0, saddr[s]}, {23'd0, a[10:2]});
            if (ws != 4'd0) begin
               chk("acc_wmask", {28'd0, wmask[s]}, {28'd0, ws});
               chk("acc_din", din[s], wd);
            end
         end
         if (ready[s]) begin
            got = 1'b1;
            chk("latency", k, exp_lat);
            exp_rd = exp_q.pop_front();
            chk("rdata", rdata[s], exp_rd);
            valid = 1'b0;
         end
      end
      valid = 1'b0;
      chk("ready_seen", {31'd0, got}, 32'd1);
      chk("csb_cycles", csb_lo, in_win ? 1 : 0);
      chk("busy_cycles", busy_n, exp_lat);
      @(negedge clk);
      chk("idle_after", {30'd0, busy[s], ready[s]}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdy_seen;
      n_checks = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      valid    = 1'b0;
      addr     = 32'd0;
      wdata    = 32'd0;
      wstrb    = 4'd0;
      clr      = 1'b0;
      sel      = 0;
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      repeat (3) @(negedge clk);

      chk("rst_ready", {31'd0, ready[0]}, 32'd0);
      chk("rst_rdata", rdata[0], 32'd0);
      chk("rst_busy", {31'd0, busy[0]}, 32'd0);
      chk("rst_csb", {31'd0, csb[0]}, 32'd1);
      chk("rst_web", {31'd0, web[0]}, 32'd1);
      chk("rst_wmask", {28'd0, wmask[0]}, 32'd0);
      chk("rst_saddr", {23'd0, saddr[0]}, 32'd0);
      chk("rst_din", din[0], 32'd0);
      chk("rst_err", {31'd0, err[0]}, 32'd0);
      chk("rst_erra", erra[0], 32'd0);
      resetn = 1'b1;

      // Write then read, READ_WAIT=0
      do_txn(0, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0);
      do_txn(0, 32'h0000_0010, 32'h0,         4'h0, 1'b0);

      // Byte strobe
      do_txn(0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 1'b0);
      do_txn(0, 32'h0000_0020, 32'h0000_00AB, 4'h1, 1'b0);
      do_txn(0, 32'h0000_0020, 32'h0,         4'h0, 1'b0);
      chk("err_still_clear", {31'd0, err[0]}, 32'd0);

      // Out-of-window write, then read
      do_txn(0, 32'h0000_0800, 32'hDEAD_BEEF, 4'hF, 1'b0);
      chk("oow_err", {31'd0, err[0]}, 32'd1);
      chk("oow_erra", erra[0], 32'h0000_0800);
      do_txn(0, 32'h0000_0800, 32'h0,         4'h0, 1'b0);

      // Clear racing with a new out-of-window decode
      do_txn(0, 32'h0000_1004, 32'h0,         4'h0, 1'b1);
      chk("race_err", {31'd0, err[0]}, 32'd1);
      chk("race_erra", erra[0], 32'h0000_1004);
      @(negedge clk);
      sel = 0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_err", {31'd0, err[0]}, 32'd0);
      chk("clr_erra_kept", erra[0], 32'h0000_1004);

      // READ_WAIT=2 instance
      do_txn(1, 32'h0000_0004, 32'hCAFE_0004, 4'hF, 1'b0);
      do_txn(1, 32'h0000_0004, 32'h0,         4'h0, 1'b0);
      do_txn(1, 32'h0000_0008, 32'h5A5A_A5A5, 4'hC, 1'b0);

      // Reset during WAIT
      @(negedge clk);
      sel   = 1;
      valid = 1'b1;
      addr  = 32'h0000_0004;
      wstrb = 4'h0;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy[1]}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy[1]}, 32'd0);
      chk("mid_rst_csb", {31'd0, csb[1]}, 32'd1);
      rdy_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (ready[1]) rdy_seen++;
      end
      chk("mid_rst_no_ready", rdy_seen, 0);
      chk("mid_rst_rdata", rdata[1], 32'd0);
      resetn     = 1'b1;
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      do_txn(1, 32'h0000_0004, 32'h0, 4'h0, 1'b0);
      do_txn(1, 32'h0000_0008, 32'h0, 4'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
